// File: rtl/fsic_axis_pkg.sv
// Shared AXI-Stream beat definitions for the FSIC serdes RX path.
package fsic_axis_pkg;

  localparam int unsigned TDATA_W = 32;
  localparam int unsigned TSTRB_W = TDATA_W / 8;
  localparam int unsigned TID_W   = 2;
  localparam int unsigned TUSER_W = 2;
  localparam int unsigned ENTRY_W = TDATA_W + 2 * TSTRB_W + 1 + TID_W + TUSER_W;

  typedef struct packed {
    logic [TDATA_W-1:0] tdata;
    logic [TSTRB_W-1:0] tstrb;
    logic [TSTRB_W-1:0] tkeep;
    logic               tlast;
    logic [TID_W-1:0]   tid;
    logic [TUSER_W-1:0] tuser;
  } beat_t;

  // Stored entry width for an arbitrary tdata width.
  function automatic int unsigned entry_width(input int unsigned data_w);
    return data_w + 2 * (data_w / 8) + 1 + TID_W + TUSER_W;
  endfunction

endpackage

// File: rtl/fsic_axis_rx_mem.sv
// Beat storage: register array, synchronous write, asynchronous read, no reset.
module fsic_axis_rx_mem #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 45
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fsic_axis_rx_buf.sv
// First-word-fall-through receive buffer between the serdes RX path and downstream,
// with registered credit-style ready back to the remote side and a sticky drop flag.
module fsic_axis_rx_buf
  import fsic_axis_pkg::*;
#(
  parameter int unsigned pDATA_WIDTH = 32,
  parameter int unsigned pFIFO_DEPTH = 8,
  parameter int unsigned pTHRESHOLD  = 3
) (
  input  logic                           axis_clk,
  input  logic                           axis_rst,
  input  logic [pDATA_WIDTH-1:0]         is_as_tdata,
  input  logic [pDATA_WIDTH/8-1:0]       is_as_tstrb,
  input  logic [pDATA_WIDTH/8-1:0]       is_as_tkeep,
  input  logic                           is_as_tlast,
  input  logic [TID_W-1:0]               is_as_tid,
  input  logic [TUSER_W-1:0]             is_as_tuser,
  input  logic                           is_as_tvalid,
  output logic [pDATA_WIDTH-1:0]         rx_tdata,
  output logic [pDATA_WIDTH/8-1:0]       rx_tstrb,
  output logic [pDATA_WIDTH/8-1:0]       rx_tkeep,
  output logic                           rx_tlast,
  output logic [TID_W-1:0]               rx_tid,
  output logic [TUSER_W-1:0]             rx_tuser,
  output logic                           rx_tvalid,
  input  logic                           rx_tready,
  output logic                           as_is_tready,
  output logic [$clog2(pFIFO_DEPTH):0]   fifo_level,
  output logic                           overflow,
  input  logic                           overflow_clr
);

  localparam int unsigned PTR_W  = $clog2(pFIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned ENT_W  = entry_width(pDATA_WIDTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             tready_q, tready_d;
  logic [CNT_W-1:0] free_c;
  logic             push, pop, full, drop;
  logic [ENT_W-1:0] wr_entry, rd_entry;

  assign full = (count_q == CNT_W'(pFIFO_DEPTH));
  assign pop  = rx_tvalid && rx_tready;
  assign push = is_as_tvalid && (!full || pop);
  assign drop = is_as_tvalid && full && !pop;

  // Next-state for pointers, occupancy, drop flag and registered ready.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (!push && pop) count_d = count_q - CNT_W'(1);
    // Set has priority over a coincident clear.
    if (drop)              overflow_d = 1'b1;
    else if (overflow_clr) overflow_d = 1'b0;
    free_c   = CNT_W'(pFIFO_DEPTH) - count_d;
    tready_d = (free_c > CNT_W'(pTHRESHOLD));
  end

  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      tready_q   <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      tready_q   <= tready_d;
    end
  end

  assign wr_entry = {is_as_tdata, is_as_tstrb, is_as_tkeep, is_as_tlast, is_as_tid, is_as_tuser};

  fsic_axis_rx_mem #(
    .DEPTH (pFIFO_DEPTH),
    .WIDTH (ENT_W)
  ) u_mem (
    .clk     (axis_clk),
    .we_i    (push && !axis_rst),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_entry),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_entry)
  );

  assign {rx_tdata, rx_tstrb, rx_tkeep, rx_tlast, rx_tid, rx_tuser} = rd_entry;
  assign rx_tvalid    = (count_q != '0);
  assign fifo_level   = count_q;
  assign overflow     = overflow_q;
  assign as_is_tready = tready_q;

endmodule
